// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm
//   Multi-cycle instruction sequencer: FETCH / DECODE / EXECUTE / MEM /
//   WRITEBACK per instruction. Waits on the imem/dmem ready handshakes with a
//   bounded wait counter, traps undefined opcodes/functs and handshake
//   timeouts, and counts retired instructions.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   run                 fetch/execute enable, sampled at instruction boundaries
//   opcode, funct_r     instruction fields from the IR
//   alu_zero            ALU result is zero (branch resolution)
//   imem_ready          instruction memory completes this cycle
//   dmem_ready          data memory completes this cycle
//   imem_req, ir_load   fetch request, IR load pulse
//   pc_write, pc_src    PC update pulse, 00 PC+4 / 01 branch / 10 jump
//   dmem_read/write     data memory requests
//   reg_write           register file write pulse
//   mem_to_reg          writeback selects memory data
//   alu_src, alu_op     ALU operand B = immediate, ALU operation
//   illegal_op          sticky trap flag: undefined opcode/funct
//   mem_timeout         sticky trap flag: handshake wait exceeded MEM_TMO
//   busy                state is neither IDLE nor TRAP
//   retired             retired-instruction count (wraps)
//
// State table
//   state      | meaning
//   S_IDLE     | parked, waits for run
//   S_FETCH    | instruction fetch, waits for imem_ready
//   S_DECODE   | one-cycle decode; J retires here, illegal traps here
//   S_EXECUTE  | one-cycle ALU; branches retire here
//   S_MEM      | data access, waits for dmem_ready; SW retires here
//   S_WRITEBACK| register write, retires
//   S_TRAP     | dead until reset, all outputs quiet
// ---------------------------------------------------------------------------
module multicycle_control_fsm #(
    parameter int OPCODE_W = 6,
    parameter int FUNCT_W  = 11,
    parameter int ALUOP_W  = 4,
    parameter int MEM_TMO  = 15,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNCT_W-1:0]  funct_r,
    input  logic                alu_zero,
    input  logic                imem_ready,
    input  logic                dmem_ready,
    output logic                imem_req,
    output logic                ir_load,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                dmem_read,
    output logic                dmem_write,
    output logic                reg_write,
    output logic                mem_to_reg,
    output logic                alu_src,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic                illegal_op,
    output logic                mem_timeout,
    output logic                busy,
    output logic [CNT_W-1:0]    retired
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_DECODE    = 3'd2;
    localparam logic [2:0] S_EXECUTE   = 3'd3;
    localparam logic [2:0] S_MEM       = 3'd4;
    localparam logic [2:0] S_WRITEBACK = 3'd5;
    localparam logic [2:0] S_TRAP      = 3'd6;

    localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(8'h00);
    localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(8'h01);
    localparam logic [OPCODE_W-1:0] OP_SUBI = OPCODE_W'(8'h02);
    localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(8'h08);
    localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(8'h09);
    localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(8'h10);
    localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(8'h12);
    localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(8'h13);
    localparam logic [OPCODE_W-1:0] OP_LI   = OPCODE_W'(8'h18);

    localparam logic [FUNCT_W-1:0] FN_ADD = FUNCT_W'(1);
    localparam logic [FUNCT_W-1:0] FN_SUB = FUNCT_W'(2);
    localparam logic [FUNCT_W-1:0] FN_SLT = FUNCT_W'(8);

    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_LI  = ALUOP_W'(3);

    // Wide enough to hold MEM_TMO itself.
    localparam int WAIT_W = $clog2(MEM_TMO + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TMO - 1);

    logic [2:0]        state, next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              retire, set_illegal, set_timeout;

    logic is_r, is_addi, is_subi, is_lw, is_sw, is_j, is_beq, is_bne, is_li;
    logic funct_ok, op_legal, is_branch, is_mem, wait_expired, boundary_fetch;
    logic [2:0] boundary_state;

    assign is_r    = (opcode == OP_R);
    assign is_addi = (opcode == OP_ADDI);
    assign is_subi = (opcode == OP_SUBI);
    assign is_lw   = (opcode == OP_LW);
    assign is_sw   = (opcode == OP_SW);
    assign is_j    = (opcode == OP_J);
    assign is_beq  = (opcode == OP_BEQ);
    assign is_bne  = (opcode == OP_BNE);
    assign is_li   = (opcode == OP_LI);

    assign funct_ok  = (funct_r == FN_ADD) || (funct_r == FN_SUB) || (funct_r == FN_SLT);
    assign op_legal  = (is_r && funct_ok) || is_addi || is_subi || is_lw || is_sw ||
                       is_j || is_beq || is_bne || is_li;
    assign is_branch = is_beq || is_bne;
    assign is_mem    = is_lw || is_sw;

    // Ready in the cycle the counter sits at MEM_TMO-1 still completes; only
    // a low ready at that point times out.
    assign wait_expired   = (wait_cnt == WAIT_LAST);
    assign boundary_fetch = run;
    assign boundary_state = boundary_fetch ? S_FETCH : S_IDLE;

    always_comb begin
        next_state  = state;
        retire      = 1'b0;
        set_illegal = 1'b0;
        set_timeout = 1'b0;
        case (state)
            S_IDLE: begin
                if (run) next_state = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ready) begin
                    next_state = S_DECODE;
                end else if (wait_expired) begin
                    next_state  = S_TRAP;
                    set_timeout = 1'b1;
                end
            end
            S_DECODE: begin
                if (is_j) begin
                    retire     = 1'b1;
                    next_state = boundary_state;
                end else if (!op_legal) begin
                    next_state  = S_TRAP;
                    set_illegal = 1'b1;
                end else begin
                    next_state = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (is_branch) begin
                    retire     = 1'b1;
                    next_state = boundary_state;
                end else if (is_mem) begin
                    next_state = S_MEM;
                end else begin
                    next_state = S_WRITEBACK;
                end
            end
            S_MEM: begin
                if (dmem_ready) begin
                    if (is_lw) begin
                        next_state = S_WRITEBACK;
                    end else begin
                        retire     = 1'b1;
                        next_state = boundary_state;
                    end
                end else if (wait_expired) begin
                    next_state  = S_TRAP;
                    set_timeout = 1'b1;
                end
            end
            S_WRITEBACK: begin
                retire     = 1'b1;
                next_state = boundary_state;
            end
            S_TRAP: begin
                next_state = S_TRAP;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    always_comb begin
        imem_req   = 1'b0;
        ir_load    = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        dmem_read  = 1'b0;
        dmem_write = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        alu_op     = ALU_ADD;
        case (state)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_load  = imem_ready;
                pc_write = imem_ready;
            end
            S_DECODE: begin
                if (is_j) begin
                    pc_write = 1'b1;
                    pc_src   = 2'b10;
                end
            end
            S_EXECUTE: begin
                alu_src = is_addi || is_subi || is_li || is_lw || is_sw;
                if (is_r) begin
                    if (funct_r == FN_SUB)      alu_op = ALU_SUB;
                    else if (funct_r == FN_SLT) alu_op = ALU_SLT;
                    else                        alu_op = ALU_ADD;
                end else if (is_subi || is_branch) begin
                    alu_op = ALU_SUB;
                end else if (is_li) begin
                    alu_op = ALU_LI;
                end
                if (is_branch) begin
                    pc_src   = 2'b01;
                    pc_write = (is_beq && alu_zero) || (is_bne && !alu_zero);
                end
            end
            S_MEM: begin
                dmem_read  = is_lw;
                dmem_write = is_sw;
            end
            S_WRITEBACK: begin
                reg_write  = 1'b1;
                mem_to_reg = is_lw;
            end
            default: begin
            end
        endcase
    end

    assign busy = (state != S_IDLE) && (state != S_TRAP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            retired     <= '0;
            illegal_op  <= 1'b0;
            mem_timeout <= 1'b0;
        end else begin
            state <= next_state;
            if ((next_state != state) && ((next_state == S_FETCH) || (next_state == S_MEM))) begin
                wait_cnt <= '0;
            end else if ((state == S_FETCH && !imem_ready) || (state == S_MEM && !dmem_ready)) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            if (retire)      retired     <= retired + CNT_W'(1);
            if (set_illegal) illegal_op  <= 1'b1;
            if (set_timeout) mem_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_fsm
//   Directed vector table, randomized instruction stream checked against an
//   instruction-level reference model, and hand-written trap/reset/run-drop
//   sequences. DUT built with CNT_W=2 so counter wrap is reachable.
// ---------------------------------------------------------------------------
module tb_multicycle_control_fsm;

    localparam logic [5:0] R = 6'h00, ADDI = 6'h01, SUBI = 6'h02, LW = 6'h08, SW = 6'h09,
                           J = 6'h10, BEQ = 6'h12, BNE = 6'h13, LI = 6'h18;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic [5:0]  opcode = '0;
    logic [10:0] funct_r = '0;
    logic        alu_zero = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
    logic        imem_req, ir_load, pc_write, dmem_read, dmem_write, reg_write, mem_to_reg;
    logic        alu_src, illegal_op, mem_timeout, busy;
    logic [1:0]  pc_src;
    logic [3:0]  alu_op;
    logic [1:0]  retired;
    logic [16:0] act;

    int checks = 0;
    int errors = 0;
    int mret   = 0;

    multicycle_control_fsm #(.OPCODE_W(6), .FUNCT_W(11), .ALUOP_W(4), .MEM_TMO(15), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .funct_r(funct_r),
        .alu_zero(alu_zero), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_load(ir_load), .pc_write(pc_write), .pc_src(pc_src),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .alu_src(alu_src), .alu_op(alu_op),
        .illegal_op(illegal_op), .mem_timeout(mem_timeout), .busy(busy), .retired(retired)
    );

    always #5 clk = ~clk;

    assign act = {imem_req, ir_load, pc_write, pc_src, dmem_read, dmem_write, reg_write,
                  mem_to_reg, alu_src, alu_op, illegal_op, mem_timeout, busy};

    function automatic logic [16:0] ov(input logic ireq, irl, pcw, input logic [1:0] pcs,
                                       input logic dr, dw, rw, m2r, asrc,
                                       input logic [3:0] aop, input logic ill, tmo, bsy);
        return {ireq, irl, pcw, pcs, dr, dw, rw, m2r, asrc, aop, ill, tmo, bsy};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Drive one cycle of inputs mid-cycle, then compare outputs before the next rising edge.
    task automatic step(input logic r, ir, dr, z, input logic [5:0] op, input logic [10:0] fn,
                        input logic [16:0] exp, input logic [1:0] er, input string nm);
        @(negedge clk);
        run = r; imem_ready = ir; dmem_ready = dr; alu_zero = z; opcode = op; funct_r = fn;
        #1;
        checks++;
        if ({act, retired} !== {exp, er}) begin
            errors++;
            $display("FAIL %s: got out=%05h retired=%0d, expected out=%05h retired=%0d",
                     nm, act, retired, exp, er);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0; run = 1'b0;
        #1;
        checks++;
        if ({act, retired} !== 19'd0) begin
            errors++;
            $display("FAIL reset: got out=%05h retired=%0d, expected out=00000 retired=0", act, retired);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mret = 0;
    endtask

    task automatic do_idle(input int n, input logic r);
        for (int k = 0; k < n; k++)
            step(r, rb(), rb(), rb(), 6'($urandom), 11'($urandom), 17'd0, 2'(mret), "idle");
    endtask

    task automatic do_trap(input int n, input logic ill, input logic tmo);
        for (int k = 0; k < n; k++)
            step(rb(), rb(), rb(), rb(), 6'($urandom), 11'($urandom),
                 ov(0,0,0,2'b00,0,0,0,0,0,4'd0,ill,tmo,0), 2'(mret), "trap");
    endtask

    // Instruction-level reference: expected per-cycle control word derived from
    // the instruction class, memory wait lengths and branch outcome.
    task automatic do_instr(input logic [5:0] op, input logic [10:0] fn, input logic z,
                            input int id, input int dd, input logic drop);
        logic r, asrc, br, taken;
        logic [3:0] aop;
        r = !drop;
        for (int k = 0; k <= id; k++)
            step(1'b1, k == id, rb(), rb(), op, fn,
                 ov(1, k == id, k == id, 2'b00, 0,0,0,0,0, 4'd0, 0,0,1), 2'(mret), "fetch");
        if (op == J) begin
            step(r, rb(), rb(), rb(), op, fn, ov(0,0,1,2'b10,0,0,0,0,0,4'd0,0,0,1), 2'(mret), "decode_j");
            mret = (mret + 1) % 4;
            return;
        end
        step(r, rb(), rb(), rb(), op, fn, ov(0,0,0,2'b00,0,0,0,0,0,4'd0,0,0,1), 2'(mret), "decode");
        case (op)
            R:       aop = (fn == 11'd2) ? 4'd1 : (fn == 11'd8) ? 4'd2 : 4'd0;
            SUBI, BEQ, BNE: aop = 4'd1;
            LI:      aop = 4'd3;
            default: aop = 4'd0;
        endcase
        asrc  = (op == ADDI) || (op == SUBI) || (op == LI) || (op == LW) || (op == SW);
        br    = (op == BEQ) || (op == BNE);
        taken = (op == BEQ) ? z : (op == BNE) ? !z : 1'b0;
        step(r, rb(), rb(), z, op, fn, ov(0,0,taken, br ? 2'b01 : 2'b00, 0,0,0,0,asrc,aop,0,0,1),
             2'(mret), "execute");
        if (br) begin
            mret = (mret + 1) % 4;
            return;
        end
        if (op == LW || op == SW) begin
            for (int k = 0; k <= dd; k++)
                step(r, rb(), k == dd, rb(), op, fn,
                     ov(0,0,0,2'b00, op == LW, op == SW, 0,0,0,4'd0,0,0,1), 2'(mret), "mem");
            if (op == SW) begin
                mret = (mret + 1) % 4;
                return;
            end
        end
        step(r, rb(), rb(), rb(), op, fn, ov(0,0,0,2'b00,0,0,1, op == LW, 0,4'd0,0,0,1),
             2'(mret), "writeback");
        mret = (mret + 1) % 4;
    endtask

    typedef struct {
        logic        r, ir, dr, z;
        logic [5:0]  op;
        logic [10:0] fn;
        logic [16:0] exp;
        logic [1:0]  er;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, ir, dr, z, input logic [5:0] op,
                                input logic [10:0] fn, input logic [16:0] exp, input logic [1:0] er);
        vec_t v;
        v.r = r; v.ir = ir; v.dr = dr; v.z = z; v.op = op; v.fn = fn; v.exp = exp; v.er = er;
        tbl.push_back(v);
    endfunction

    localparam logic [16:0] BSY = 17'h00001;
    localparam logic [16:0] FET = 17'h1C001;

    logic [5:0] legal_ops [9];
    logic [5:0] op;
    logic [10:0] fn;
    int id, dd;

    initial begin
        legal_ops = '{R, ADDI, SUBI, LW, SW, J, BEQ, BNE, LI};

        // Directed table: ADD, LW (3 wait), BEQ taken, BNE not taken, J, SW, park.
        add(1,0,0,0, R,1, 17'd0, 0);
        add(1,1,0,0, R,1, FET, 0);
        add(1,0,0,0, R,1, BSY, 0);
        add(1,0,0,0, R,1, ov(0,0,0,2'b00,0,0,0,0,0,4'd0,0,0,1), 0);
        add(1,0,0,0, R,1, ov(0,0,0,2'b00,0,0,1,0,0,4'd0,0,0,1), 0);
        add(1,1,0,0, LW,0, FET, 1);
        add(1,0,0,0, LW,0, BSY, 1);
        add(1,0,0,0, LW,0, ov(0,0,0,2'b00,0,0,0,0,1,4'd0,0,0,1), 1);
        add(1,0,0,0, LW,0, ov(0,0,0,2'b00,1,0,0,0,0,4'd0,0,0,1), 1);
        add(1,0,0,0, LW,0, ov(0,0,0,2'b00,1,0,0,0,0,4'd0,0,0,1), 1);
        add(1,0,0,0, LW,0, ov(0,0,0,2'b00,1,0,0,0,0,4'd0,0,0,1), 1);
        add(1,0,1,0, LW,0, ov(0,0,0,2'b00,1,0,0,0,0,4'd0,0,0,1), 1);
        add(1,0,0,0, LW,0, ov(0,0,0,2'b00,0,0,1,1,0,4'd0,0,0,1), 1);
        add(1,1,0,0, BEQ,0, FET, 2);
        add(1,0,0,0, BEQ,0, BSY, 2);
        add(1,0,0,1, BEQ,0, ov(0,0,1,2'b01,0,0,0,0,0,4'd1,0,0,1), 2);
        add(1,1,0,0, BNE,0, FET, 3);
        add(1,0,0,0, BNE,0, BSY, 3);
        add(1,0,0,1, BNE,0, ov(0,0,0,2'b01,0,0,0,0,0,4'd1,0,0,1), 3);
        add(1,1,0,0, J,0, FET, 0);
        add(1,0,0,0, J,0, ov(0,0,1,2'b10,0,0,0,0,0,4'd0,0,0,1), 0);
        add(1,1,0,0, SW,0, FET, 1);
        add(1,0,0,0, SW,0, BSY, 1);
        add(1,0,0,0, SW,0, ov(0,0,0,2'b00,0,0,0,0,1,4'd0,0,0,1), 1);
        add(0,0,1,0, SW,0, ov(0,0,0,2'b00,0,1,0,0,0,4'd0,0,0,1), 1);
        add(0,0,0,0, SW,0, 17'd0, 2);
        add(0,1,1,0, SW,0, 17'd0, 2);

        do_reset();
        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i].r, tbl[i].ir, tbl[i].dr, tbl[i].z, tbl[i].op, tbl[i].fn,
                 tbl[i].exp, tbl[i].er, $sformatf("tbl[%0d]", i));

        // Randomized instruction stream against the reference model.
        do_reset();
        do_idle(1, 1'b1);
        for (int i = 0; i < 80; i++) begin
            op = legal_ops[$urandom_range(0, 8)];
            fn = (op == R) ? ((($urandom_range(0, 2)) == 0) ? 11'd1 :
                              (($urandom_range(0, 1)) == 0) ? 11'd2 : 11'd8) : 11'($urandom);
            id = ($urandom_range(0, 7) == 0) ? 14 : int'($urandom_range(0, 3));
            dd = ($urandom_range(0, 7) == 0) ? 14 : int'($urandom_range(0, 3));
            do_instr(op, fn, rb(), id, dd, 1'b0);
        end
        // Ready on the last allowed wait cycle completes normally.
        do_instr(ADDI, 11'd0, 1'b0, 14, 0, 1'b0);
        do_instr(SW, 11'd0, 1'b0, 0, 14, 1'b1);
        do_idle(2, 1'b0);

        // Undefined opcode traps after DECODE.
        do_reset();
        do_idle(1, 1'b1);
        step(1,1,0,0, 6'h3F,0, FET, 0, "ill_fetch");
        step(1,0,0,0, 6'h3F,0, BSY, 0, "ill_decode");
        do_trap(4, 1'b1, 1'b0);

        // R-type with undefined funct traps the same way.
        do_reset();
        do_idle(1, 1'b1);
        step(1,1,0,0, R,4, FET, 0, "illf_fetch");
        step(1,0,0,0, R,4, BSY, 0, "illf_decode");
        do_trap(4, 1'b1, 1'b0);

        // imem_ready stuck low: 15 request cycles then timeout trap.
        do_reset();
        do_idle(1, 1'b1);
        for (int k = 0; k < 15; k++)
            step(1,0,0,0, ADDI,0, ov(1,0,0,2'b00,0,0,0,0,0,4'd0,0,0,1), 0, "imem_wait");
        do_trap(4, 1'b0, 1'b1);

        // dmem_ready stuck low on LW: 15 read cycles then timeout trap.
        do_reset();
        do_idle(1, 1'b1);
        step(1,1,0,0, LW,0, FET, 0, "dtmo_fetch");
        step(1,0,0,0, LW,0, BSY, 0, "dtmo_decode");
        step(1,0,0,0, LW,0, ov(0,0,0,2'b00,0,0,0,0,1,4'd0,0,0,1), 0, "dtmo_exec");
        for (int k = 0; k < 15; k++)
            step(1,0,0,0, LW,0, ov(0,0,0,2'b00,1,0,0,0,0,4'd0,0,0,1), 0, "dmem_wait");
        do_trap(4, 1'b0, 1'b1);

        // Five ADDIs with run dropped during the third: retired 1,2,3 then 0,1.
        do_reset();
        do_idle(1, 1'b1);
        do_instr(ADDI, 0, 0, 0, 0, 1'b0);
        do_instr(ADDI, 0, 0, 0, 0, 1'b0);
        do_instr(ADDI, 0, 0, 1, 0, 1'b1);
        do_idle(3, 1'b0);
        do_idle(1, 1'b1);
        do_instr(ADDI, 0, 0, 0, 0, 1'b0);
        do_instr(ADDI, 0, 0, 0, 0, 1'b1);
        do_idle(2, 1'b0);

        // Reset asserted while a load waits in MEM.
        do_reset();
        do_idle(1, 1'b1);
        step(1,1,0,0, LW,0, FET, 0, "rst_fetch");
        step(1,0,0,0, LW,0, BSY, 0, "rst_decode");
        step(1,0,0,0, LW,0, ov(0,0,0,2'b00,0,0,0,0,1,4'd0,0,0,1), 0, "rst_exec");
        step(1,0,0,0, LW,0, ov(0,0,0,2'b00,1,0,0,0,0,4'd0,0,0,1), 0, "rst_mem");
        do_reset();
        do_idle(2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
